// File: rtl/generic_banked_double_port_sram.sv
// One-write/one-read SRAM model with low-order bank interleaving, a READ_LATENCY-deep read pipeline and a post-reset clear engine.
// Define GENERIC_SRAM_RW_BYPASS_EN for write-first same-address collisions; the default build is read-first.
module generic_banked_double_port_sram #(
    parameter int               WIDTH          = 128,
    parameter int               NUM_ROWS       = 4096,
    parameter int               NUM_BANKS      = 4,
    parameter int               READ_LATENCY   = 1,
    parameter bit               CLEAR_ON_RESET = 1'b1,
    parameter logic [WIDTH-1:0] CLEAR_VALUE    = '0,
    localparam int              AddressWidth   = $clog2(NUM_ROWS)
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic                    REB,
    input  logic                    WEB,
    input  logic [AddressWidth-1:0] AA,
    input  logic [AddressWidth-1:0] AB,
    input  logic [WIDTH-1:0]        D,
    input  logic [WIDTH-1:0]        M,
    output logic [WIDTH-1:0]        Q,
    output logic                    QV,
    output logic                    BUSY
);

    localparam int RowsPerBank = NUM_ROWS / NUM_BANKS;
    localparam int BankW       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int RowW        = (RowsPerBank > 1) ? $clog2(RowsPerBank) : 1;

    typedef enum logic {
        ST_READY = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    function automatic logic [BankW-1:0] bank_of(input logic [AddressWidth-1:0] addr);
        return BankW'(32'(addr) % NUM_BANKS);
    endfunction

    function automatic logic [RowW-1:0] row_of(input logic [AddressWidth-1:0] addr);
        return RowW'(32'(addr) / NUM_BANKS);
    endfunction

    function automatic logic [WIDTH-1:0] merge_word(input logic [WIDTH-1:0] old_w,
                                                    input logic [WIDTH-1:0] new_w,
                                                    input logic [WIDTH-1:0] mask);
        return (new_w & mask) | (old_w & ~mask);
    endfunction

    logic [WIDTH-1:0] mem_q       [NUM_BANKS][RowsPerBank];
    logic             mem_we_d    [NUM_BANKS];
    logic [RowW-1:0]  mem_row_d   [NUM_BANKS];
    logic [WIDTH-1:0] mem_wdata_d [NUM_BANKS];

    state_e          state_q, state_d;
    logic [RowW-1:0] clr_cnt_q, clr_cnt_d;

    logic [WIDTH-1:0]        rd_data_p_q [READ_LATENCY];
    logic [WIDTH-1:0]        rd_data_p_d [READ_LATENCY];
    logic [READ_LATENCY-1:0] rd_vld_p_q, rd_vld_p_d;

    logic [BankW-1:0] wr_bank, rd_bank;
    logic [RowW-1:0]  wr_row, rd_row;
    logic [WIDTH-1:0] wr_old, wr_merged, rd_old, rd_word;
    logic             wr_fire, rd_launch;

    assign wr_bank   = bank_of(AA);
    assign wr_row    = row_of(AA);
    assign rd_bank   = bank_of(AB);
    assign rd_row    = row_of(AB);
    assign wr_old    = mem_q[wr_bank][wr_row];
    assign rd_old    = mem_q[rd_bank][rd_row];
    assign wr_merged = merge_word(wr_old, D, M);

    // Accesses are only honoured out of reset and once the clear engine is idle.
    assign wr_fire   = RSTN && (state_q == ST_READY) && WEB;
    assign rd_launch = RSTN && (state_q == ST_READY) && REB;

`ifdef GENERIC_SRAM_RW_BYPASS_EN
    assign rd_word = (wr_fire && (AA == AB)) ? wr_merged : rd_old;
`else
    assign rd_word = rd_old;
`endif

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            mem_we_d[b]    = 1'b0;
            mem_row_d[b]   = clr_cnt_q;
            mem_wdata_d[b] = CLEAR_VALUE;
        end
        if (state_q == ST_CLEAR) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                mem_we_d[b] = RSTN;
            end
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == RowW'(RowsPerBank - 1)) begin
                state_d = ST_READY;
            end
        end else if (wr_fire) begin
            mem_we_d[wr_bank]    = 1'b1;
            mem_row_d[wr_bank]   = wr_row;
            mem_wdata_d[wr_bank] = wr_merged;
        end
    end

    // Read pipeline: each stage's data only advances with a valid beat, so Q holds between reads.
    always_comb begin
        rd_vld_p_d[0]  = rd_launch;
        rd_data_p_d[0] = rd_launch ? rd_word : rd_data_p_q[0];
        for (int k = 1; k < READ_LATENCY; k++) begin
            rd_vld_p_d[k]  = rd_vld_p_q[k-1];
            rd_data_p_d[k] = rd_vld_p_q[k-1] ? rd_data_p_q[k-1] : rd_data_p_q[k];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            clr_cnt_q  <= '0;
            rd_vld_p_q <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                rd_data_p_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rd_vld_p_q <= rd_vld_p_d;
            for (int k = 0; k < READ_LATENCY; k++) begin
                rd_data_p_q[k] <= rd_data_p_d[k];
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (mem_we_d[b]) begin
                mem_q[b][mem_row_d[b]] <= mem_wdata_d[b];
            end
        end
    end

    assign Q    = rd_data_p_q[READ_LATENCY-1];
    assign QV   = rd_vld_p_q[READ_LATENCY-1];
    assign BUSY = !RSTN || (state_q == ST_CLEAR);

endmodule

// File: tb/tb_generic_banked_double_port_sram.sv
// Directed bench for generic_banked_double_port_sram: two instances (READ_LATENCY 3 and 2) share one stimulus stream.
module tb_generic_banked_double_port_sram;

    logic        CLK = 1'b0;
    logic        RSTN, REB, WEB;
    logic [5:0]  AA, AB;
    logic [15:0] D, M;
    logic [15:0] q3, q2;
    logic        qv3, qv2, busy3, busy2;
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] vals [3];

`ifdef GENERIC_SRAM_RW_BYPASS_EN
    localparam logic [15:0] CollExp = 16'h003C;
`else
    localparam logic [15:0] CollExp = 16'h0000;
`endif

    always #5 CLK = ~CLK;

    generic_banked_double_port_sram #(
        .WIDTH(16), .NUM_ROWS(64), .NUM_BANKS(4), .READ_LATENCY(3),
        .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(16'h00A5)
    ) u_l3 (
        .CLK(CLK), .RSTN(RSTN), .REB(REB), .WEB(WEB), .AA(AA), .AB(AB),
        .D(D), .M(M), .Q(q3), .QV(qv3), .BUSY(busy3)
    );

    generic_banked_double_port_sram #(
        .WIDTH(16), .NUM_ROWS(64), .NUM_BANKS(4), .READ_LATENCY(2),
        .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(16'h00A5)
    ) u_l2 (
        .CLK(CLK), .RSTN(RSTN), .REB(REB), .WEB(WEB), .AA(AA), .AB(AB),
        .D(D), .M(M), .Q(q2), .QV(qv2), .BUSY(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input int n);
        RSTN = 1'b0;
        repeat (n) step();
        chk("rst_busy3", 32'(busy3), 32'd1);
        chk("rst_busy2", 32'(busy2), 32'd1);
        chk("rst_q3", 32'(q3), 32'd0);
        chk("rst_qv3", 32'(qv3), 32'd0);
        chk("rst_q2", 32'(q2), 32'd0);
        chk("rst_qv2", 32'(qv2), 32'd0);
        RSTN = 1'b1;
        #1;
    endtask

    task automatic clear_watch(input string tag, input bit poke);
        int nb3 = 0;
        int nb2 = 0;
        int nq3 = 0;
        int nq2 = 0;
        for (int i = 0; i < 20; i++) begin
            nb3 += int'(busy3);
            nb2 += int'(busy2);
            if (poke && i == 4) begin
                WEB = 1'b1; AA = 6'd3; D = 16'h0001; M = 16'hFFFF;
                REB = 1'b1; AB = 6'd3;
            end
            if (poke && i == 7) begin
                WEB = 1'b0; REB = 1'b0;
            end
            step();
            nq3 += int'(qv3);
            nq2 += int'(qv2);
        end
        chk({tag, "_busy3"}, 32'(nb3), 32'd16);
        chk({tag, "_busy2"}, 32'(nb2), 32'd16);
        chk({tag, "_qv3"}, 32'(nq3), 32'd0);
        chk({tag, "_qv2"}, 32'(nq2), 32'd0);
    endtask

    task automatic access(input string tag, input bit do_wr, input logic [5:0] wa,
                          input logic [15:0] wd, input logic [15:0] wm,
                          input logic [5:0] ra, input logic [15:0] exp);
        WEB = do_wr; AA = wa; D = wd; M = wm;
        REB = 1'b1; AB = ra;
        step();
        WEB = 1'b0; REB = 1'b0;
        chk({tag, "_qv2_t0"}, 32'(qv2), 32'd0);
        chk({tag, "_qv3_t0"}, 32'(qv3), 32'd0);
        step();
        chk({tag, "_q2"}, 32'(q2), 32'(exp));
        chk({tag, "_qv2_t1"}, 32'(qv2), 32'd1);
        chk({tag, "_qv3_t1"}, 32'(qv3), 32'd0);
        step();
        chk({tag, "_q3"}, 32'(q3), 32'(exp));
        chk({tag, "_qv3_t2"}, 32'(qv3), 32'd1);
        chk({tag, "_qv2_t2"}, 32'(qv2), 32'd0);
    endtask

    task automatic rd(input string tag, input logic [5:0] ra, input logic [15:0] exp);
        access(tag, 1'b0, 6'd0, 16'h0000, 16'h0000, ra, exp);
    endtask

    task automatic wr(input logic [5:0] wa, input logic [15:0] wd, input logic [15:0] wm);
        WEB = 1'b1; AA = wa; D = wd; M = wm;
        step();
        WEB = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        RSTN = 1'b0; REB = 1'b0; WEB = 1'b0;
        AA = '0; AB = '0; D = '0; M = '0;
        vals[0] = 16'd10; vals[1] = 16'd11; vals[2] = 16'd12;

        // Reset, clear length, and accesses poked while the clear runs
        do_reset(2);
        clear_watch("clr", 1'b1);
        rd("busy_acc3", 6'd3, 16'h00A5);
        rd("clr0", 6'd0, 16'h00A5);
        rd("clr63", 6'd63, 16'h00A5);

        // Masked writes
        wr(6'd5, 16'hFFFF, 16'h00FF);
        rd("mask", 6'd5, 16'h00FF);
        wr(6'd5, 16'hFFFF, 16'h0000);
        rd("mask0", 6'd5, 16'h00FF);

        // Back-to-back reads through both pipeline depths
        wr(6'd0, 16'd10, 16'hFFFF);
        wr(6'd1, 16'd11, 16'hFFFF);
        wr(6'd2, 16'd12, 16'hFFFF);
        for (int c = 0; c < 6; c++) begin
            REB = (c < 3);
            AB  = 6'(c);
            step();
            if (c >= 2 && c <= 4) begin
                chk("b2b_q3", 32'(q3), 32'(vals[c-2]));
                chk("b2b_qv3", 32'(qv3), 32'd1);
            end else begin
                chk("b2b_qv3_idle", 32'(qv3), 32'd0);
            end
            if (c >= 1 && c <= 3) begin
                chk("b2b_q2", 32'(q2), 32'(vals[c-1]));
                chk("b2b_qv2", 32'(qv2), 32'd1);
            end else begin
                chk("b2b_qv2_idle", 32'(qv2), 32'd0);
            end
        end
        REB = 1'b0;
        chk("hold_q3", 32'(q3), 32'd12);
        chk("hold_q2", 32'(q2), 32'd12);

        // Same-address collision, then same bank at different rows
        wr(6'd7, 16'h0000, 16'hFFFF);
        access("coll", 1'b1, 6'd7, 16'h003C, 16'hFFFF, 6'd7, CollExp);
        rd("coll_after", 6'd7, 16'h003C);
        wr(6'd4, 16'h1234, 16'hFFFF);
        access("bank", 1'b1, 6'd8, 16'h5555, 16'hFFFF, 6'd4, 16'h1234);
        rd("bank8", 6'd8, 16'h5555);

        // Reset part-way through a clear restarts it from row 0
        wr(6'd60, 16'h7777, 16'hFFFF);
        rd("pre60", 6'd60, 16'h7777);
        do_reset(1);
        repeat (8) step();
        do_reset(1);
        clear_watch("reclr", 1'b0);
        rd("reclr60", 6'd60, 16'h00A5);

        // Reset with a read in flight discards it
        wr(6'd10, 16'hBEEF, 16'hFFFF);
        REB = 1'b1; AB = 6'd10;
        step();
        REB = 1'b0;
        RSTN = 1'b0;
        step();
        chk("flush_qv2", 32'(qv2), 32'd0);
        chk("flush_q2", 32'(q2), 32'd0);
        chk("flush_qv3", 32'(qv3), 32'd0);
        chk("flush_q3", 32'(q3), 32'd0);
        RSTN = 1'b1;
        #1;
        clear_watch("flush", 1'b0);
        rd("post_flush", 6'd10, 16'h00A5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
